// File: rtl/servo_pkg.sv
// Shared types, widths and the position-to-pulse-width conversion for the servo path.
package servo_pkg;

  localparam int unsigned WIDTH_W        = 17;
  localparam int unsigned POS_W          = 8;
  localparam int unsigned HOLD_W         = 8;
  localparam int unsigned MIN_TICKS_DEF  = 50000;
  localparam int unsigned STEP_TICKS_DEF = 196;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_MOVE   = 2'd2,
    ST_RETURN = 2'd3
  } state_e;

  // Command payload captured on the accept cycle.
  typedef struct packed {
    logic [POS_W-1:0]  pos;
    logic [HOLD_W-1:0] hold;
    logic              ret;
  } cmd_t;

  // Pulse width in clk ticks for a position; fits 17 bits for pos 0..255 with the defaults.
  function automatic logic [WIDTH_W-1:0] pos_to_ticks(input logic [POS_W-1:0] pos,
                                                      input int unsigned min_ticks,
                                                      input int unsigned step_ticks);
    return WIDTH_W'(min_ticks + 32'(pos) * step_ticks);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester that did not win last time has priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] ready_c_o,
  output logic       grant_c_o,
  output logic       last_grant_o
);

  logic last_grant_q, last_grant_d;
  logic pick;

  // Pick the winner and raise at most one ready bit.
  always_comb begin
    pick         = valid_i[1];
    ready_c_o    = 2'b00;
    last_grant_d = last_grant_q;
    if (&valid_i) begin
      pick = ~last_grant_q;
    end
    if (en_i && (|valid_i)) begin
      ready_c_o[pick] = 1'b1;
    end
    if (accept_i) begin
      last_grant_d = pick;
    end
  end

  // Remember the last winner; reset favours requester A on the first contest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign grant_c_o    = pick;
  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/servo_move_scheduler.sv
// Shares one servo channel between two requesters; all PWM updates land on frame boundaries.
module servo_move_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned MIN_TICKS     = MIN_TICKS_DEF,
  parameter int unsigned STEP_TICKS    = STEP_TICKS_DEF,
  parameter int unsigned HOME_POS      = 0,
  parameter int unsigned RETURN_FRAMES = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [15:0]        req_pos,
  input  logic [15:0]        req_hold,
  input  logic [1:0]         req_ret,
  output logic [WIDTH_W-1:0] pwm_width,
  output logic               pwm_enable,
  output logic               busy,
  output logic               grant_id,
  output logic               done
);

  localparam logic [WIDTH_W-1:0] HOME_TICKS = pos_to_ticks(POS_W'(HOME_POS), MIN_TICKS, STEP_TICKS);
  localparam logic [HOLD_W-1:0]  RET_CNT    = HOLD_W'(RETURN_FRAMES);

  state_e              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic                grant_q, grant_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH_W-1:0]  width_q, width_d;
  logic                enable_q, enable_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                arb_en;
  logic                accept;
  logic                grant_c;
  logic                last_grant;

  assign arb_en = (state_q == ST_IDLE);
  assign accept = arb_en && (|(req_valid & req_ready));

  rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (arb_en),
    .valid_i      (req_valid),
    .accept_i     (accept),
    .ready_c_o    (req_ready),
    .grant_c_o    (grant_c),
    .last_grant_o (last_grant)
  );

  // Next-state and output logic; every change to the PWM inputs is gated by frame_tick.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    enable_d = enable_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d.pos  = grant_c ? req_pos[15:8]  : req_pos[7:0];
          cmd_d.hold = grant_c ? req_hold[15:8] : req_hold[7:0];
          cmd_d.ret  = req_ret[grant_c];
          grant_d    = grant_c;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        if (frame_tick) begin
          width_d  = pos_to_ticks(cmd_q.pos, MIN_TICKS, STEP_TICKS);
          enable_d = 1'b1;
          cnt_d    = (cmd_q.hold == '0) ? HOLD_W'(1) : cmd_q.hold;
          state_d  = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (frame_tick) begin
          if (cnt_q <= HOLD_W'(1)) begin
            if (cmd_q.ret) begin
              width_d = HOME_TICKS;
              cnt_d   = RET_CNT;
              state_d = ST_RETURN;
            end else begin
              enable_d = 1'b0;
              done_d   = 1'b1;
              state_d  = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
      end
      ST_RETURN: begin
        if (frame_tick) begin
          // A count of zero (no return frames) also releases on the first tick.
          if (cnt_q <= HOLD_W'(1)) begin
            enable_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      grant_q  <= 1'b0;
      cnt_q    <= '0;
      width_q  <= HOME_TICKS;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign pwm_width  = width_q;
  assign pwm_enable = enable_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign done       = done_q;

endmodule

// File: tb/tb_servo_move_scheduler.sv
// Scoreboard bench for servo_move_scheduler: stimulus pushes expected command outcomes,
// a negedge monitor reconstructs each command from the PWM outputs and checks it on done.
module tb_servo_move_scheduler;

  localparam int unsigned FRAME_PER = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req_pos = 16'h0;
  logic [15:0] req_hold = 16'h0;
  logic [1:0]  req_ret = 2'b00;
  logic [16:0] pwm_width;
  logic        pwm_enable;
  logic        busy;
  logic        grant_id;
  logic        done;

  logic        auto_en = 1'b0;
  logic        force_tick = 1'b0;
  int unsigned fcnt = 0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        grant;
    logic [16:0] arm_w;
    int          frames;
    logic [16:0] fin_w;
  } exp_t;

  exp_t exp_q[$];

  servo_move_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pos    (req_pos),
    .req_hold   (req_hold),
    .req_ret    (req_ret),
    .pwm_width  (pwm_width),
    .pwm_enable (pwm_enable),
    .busy       (busy),
    .grant_id   (grant_id),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) fcnt <= (fcnt == FRAME_PER - 1) ? 0 : fcnt + 1;

  assign frame_tick = (auto_en && (fcnt == 0)) || force_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic g, input logic [16:0] aw, input int fr, input logic [16:0] fw);
    exp_t e;
    e.grant  = g;
    e.arm_w  = aw;
    e.frames = fr;
    e.fin_w  = fw;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Present one command and hold it until the DUT accepts it (bounded).
  task automatic issue(input int id, input logic [7:0] pos, input logic [7:0] hold, input logic ret);
    logic got;
    got = 1'b0;
    if (id == 0) begin
      req_pos[7:0] = pos; req_hold[7:0] = hold; req_ret[0] = ret;
    end else begin
      req_pos[15:8] = pos; req_hold[15:8] = hold; req_ret[1] = ret;
    end
    req_valid[id] = 1'b1;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready[id]) begin
        got = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
    check("accept", 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("wait_idle", 32'(ok), 32'd1);
  endtask

  task automatic pulse_tick();
    force_tick = 1'b1;
    @(posedge clk);
    #1;
    force_tick = 1'b0;
  endtask

  // Both requesters valid at once; expect_id is the one that must win.
  task automatic contest(input logic expect_id);
    req_pos   = {8'd20, 8'd10};
    req_hold  = {8'd1, 8'd1};
    req_ret   = 2'b00;
    push_exp(expect_id, expect_id ? 17'd53920 : 17'd51960, 1, expect_id ? 17'd53920 : 17'd51960);
    req_valid = 2'b11;
    #1;
    check("arb_ready", 32'(req_ready), expect_id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("arb_grant", 32'(grant_id), 32'(expect_id));
    wait_idle(400);
  endtask

  // Monitor: rebuild each command from the PWM outputs and score it when done pulses.
  logic [16:0] mon_arm_w = '0;
  int          mon_frames = 0;
  logic        mon_prev_en = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_frames  = 0;
      mon_prev_en = 1'b0;
    end else begin
      if (pwm_enable && !mon_prev_en) begin
        mon_arm_w  = pwm_width;
        mon_frames = 0;
      end
      if (frame_tick && pwm_enable) mon_frames++;
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no pending command (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_grant", 32'(grant_id), 32'(e.grant));
          check("done_arm_width", 32'(mon_arm_w), 32'(e.arm_w));
          check("done_frames", 32'(mon_frames), 32'(e.frames));
          check("done_final_width", 32'(pwm_width), 32'(e.fin_w));
          check("done_enable_low", 32'(pwm_enable), 32'd0);
        end
      end
      mon_prev_en = pwm_enable;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    // Reset values
    do_reset();
    check("rst_width", 32'(pwm_width), 32'd50000);
    check("rst_enable", 32'(pwm_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    auto_en = 1'b1;

    // A: full-scale position, three frames, no return
    push_exp(1'b0, 17'd99980, 3, 17'd99980);
    issue(0, 8'd255, 8'd3, 1'b0);
    check("busy_after_accept", 32'(busy), 32'd1);
    req_valid[1] = 1'b1;
    #1;
    check("ready_low_when_busy", 32'(req_ready), 32'd0);
    req_valid[1] = 1'b0;
    wait_idle(400);

    // Round-robin from reset: A, B, A
    do_reset();
    contest(1'b0);
    contest(1'b1);
    contest(1'b0);

    // B: mid position, two frames, then return home
    push_exp(1'b1, 17'd75088, 2 + 25, 17'd50000);
    issue(1, 8'd128, 8'd2, 1'b1);
    wait_idle(1500);

    // frame_tick in the accept cycle must not arm
    auto_en = 1'b0;
    push_exp(1'b0, 17'd59800, 1, 17'd59800);
    req_pos[7:0]  = 8'd50;
    req_hold[7:0] = 8'd1;
    req_ret[0]    = 1'b0;
    req_valid[0]  = 1'b1;
    force_tick    = 1'b1;
    #1;
    check("coinc_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    force_tick = 1'b0;
    req_valid  = 2'b00;
    check("coinc_enable", 32'(pwm_enable), 32'd0);
    check("coinc_busy", 32'(busy), 32'd1);
    check("coinc_width", 32'(pwm_width), 32'd50000);
    repeat (4) @(posedge clk);
    #1;
    check("coinc_still_unarmed", 32'(pwm_enable), 32'd0);
    pulse_tick();
    check("coinc_armed_enable", 32'(pwm_enable), 32'd1);
    check("coinc_armed_width", 32'(pwm_width), 32'd59800);
    repeat (3) @(posedge clk);
    #1;
    pulse_tick();
    wait_idle(50);
    auto_en = 1'b1;

    // hold=0 acts as hold=1
    push_exp(1'b0, 17'd50000, 1, 17'd50000);
    issue(0, 8'd0, 8'd0, 1'b0);
    wait_idle(400);

    // Reset in the middle of a move discards the command
    issue(0, 8'd200, 8'd5, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pwm_enable) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("midrst_armed", 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_enable", 32'(pwm_enable), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_width", 32'(pwm_width), 32'd50000);
    check("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    push_exp(1'b0, 17'd99980, 2, 17'd99980);
    issue(0, 8'd255, 8'd2, 1'b0);
    wait_idle(400);

    repeat (40) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
